// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: program-load front end for the single-cycle core.
// It accepts decoded instruction fields over a valid/ready handshake,
// re-encodes each bundle into a 32-bit RV32I word, and writes the words to
// consecutive instruction-memory addresses.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   InValid/InReady     field-bundle handshake (InReady depends on state only)
//   InLast              marks the final instruction of the program
//   Fmt                 format code (ImmSrc encoding); 011 and 100 are illegal
//   OpCode, Rd, Rs1, Rs2, Funct3, Funct7, Imm   decoded fields, Imm unscrambled
//   IMWr, IMAddr, IMData  registered instruction-memory write port
//   Count               number of words written
//   Done, Full, Err     load complete / memory full / sticky illegal-format flag
module instr_encoder_loader #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic                     InLast,
  input  logic [2:0]               Fmt,
  input  logic [6:0]               OpCode,
  input  logic [4:0]               Rd,
  input  logic [4:0]               Rs1,
  input  logic [4:0]               Rs2,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  input  logic [31:0]              Imm,
  output logic                     IMWr,
  output logic [31:0]              IMAddr,
  output logic [31:0]              IMData,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Done,
  output logic                     Full,
  output logic                     Err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_U = 3'b010;
  localparam logic [2:0] FMT_B = 3'b101;
  localparam logic [2:0] FMT_J = 3'b110;
  localparam logic [2:0] FMT_R = 3'b111;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_DONE = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_imwr;
  logic [31:0]     r_imaddr;
  logic [31:0]     r_imdata;
  logic [CW-1:0]   r_count;
  logic            r_done;
  logic            r_full;
  logic            r_err;

  logic            w_accept;
  logic            w_legal;
  logic [31:0]     w_word;
  logic [CW-1:0]   w_count_next;
  logic            w_fills;

  // Field packing per format; fields a format does not carry stay zero.
  always_comb begin
    w_legal = 1'b1;
    w_word  = '0;
    case (Fmt)
      FMT_I: begin
        // SLLI/SRLI/SRAI carry Funct7 above a 5-bit shift amount.
        if (Funct3 == 3'b001 || Funct3 == 3'b101)
          w_word = {Funct7, Imm[4:0], Rs1, Funct3, Rd, OpCode};
        else
          w_word = {Imm[11:0], Rs1, Funct3, Rd, OpCode};
      end
      FMT_S: w_word = {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], OpCode};
      FMT_U: w_word = {Imm[31:12], Rd, OpCode};
      FMT_B: w_word = {Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], OpCode};
      FMT_J: w_word = {Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, OpCode};
      FMT_R: w_word = {Funct7, Rs2, Rs1, Funct3, Rd, OpCode};
      default: w_legal = 1'b0;
    endcase
  end

  assign w_accept     = InValid && InReady;
  assign w_count_next = r_count + CW'(1);
  assign w_fills      = w_legal && (w_count_next == CW'(DEPTH));

  // Load FSM with registered write port and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_LOAD;
      r_imwr   <= 1'b0;
      r_imaddr <= BASE_ADDR;
      r_imdata <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_full   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_imwr <= 1'b0;
      if (w_accept) begin
        if (w_legal) begin
          r_imwr   <= 1'b1;
          r_imaddr <= BASE_ADDR + 32'({r_count, 2'b00});
          r_imdata <= w_word;
          r_count  <= w_count_next;
          if (w_fills) r_full <= 1'b1;
        end else begin
          // Illegal bundles are swallowed without a write.
          r_err <= 1'b1;
        end
        if (InLast || w_fills) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign InReady = (r_state == S_LOAD) && !r_full;
  assign IMWr    = r_imwr;
  assign IMAddr  = r_imaddr;
  assign IMData  = r_imdata;
  assign Count   = r_count;
  assign Done    = r_done;
  assign Full    = r_full;
  assign Err     = r_err;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed testbench for instr_encoder_loader: a DEPTH=64 instance for the
// general scenarios and a DEPTH=4 instance for the full/backpressure case.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst, s_rst;
  logic        InValid, s_valid;
  logic        InLast;
  logic [2:0]  Fmt;
  logic [6:0]  OpCode;
  logic [4:0]  Rd, Rs1, Rs2;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [31:0] Imm;

  logic        InReady, IMWr, Done, Full, Err;
  logic [31:0] IMAddr, IMData;
  logic [6:0]  Count;

  logic        s_ready, s_imwr, s_done, s_full, s_err;
  logic [31:0] s_imaddr, s_imdata;
  logic [2:0]  s_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.DEPTH(64), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady), .InLast(InLast),
    .Fmt(Fmt), .OpCode(OpCode), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Funct3(Funct3),
    .Funct7(Funct7), .Imm(Imm), .IMWr(IMWr), .IMAddr(IMAddr), .IMData(IMData),
    .Count(Count), .Done(Done), .Full(Full), .Err(Err)
  );

  instr_encoder_loader #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut_small (
    .clk(clk), .rst(s_rst), .InValid(s_valid), .InReady(s_ready), .InLast(InLast),
    .Fmt(Fmt), .OpCode(OpCode), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Funct3(Funct3),
    .Funct7(Funct7), .Imm(Imm), .IMWr(s_imwr), .IMAddr(s_imaddr), .IMData(s_imdata),
    .Count(s_count), .Done(s_done), .Full(s_full), .Err(s_err)
  );

  // Advance one edge and step to a sampling point away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im, input logic last);
    Fmt = f; OpCode = op; Rd = rd; Rs1 = r1; Rs2 = r2;
    Funct3 = f3; Funct7 = f7; Imm = im; InLast = last;
  endtask

  // ADDI rd, x0, imm
  task automatic set_addi(input logic [4:0] rd, input logic [31:0] im);
    set_fields(3'b000, 7'h13, rd, 5'd0, 5'd0, 3'b000, 7'h00, im, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; s_rst = 1'b1; InValid = 1'b0; s_valid = 1'b0;
    tick(); tick();
    rst = 1'b0; s_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL reset_inready got %b want 1", InReady); end
    n_checks++; if (IMWr !== 1'b0) begin n_fail++; $display("FAIL reset_imwr got %b want 0", IMWr); end
    n_checks++; if (IMAddr !== 32'h0) begin n_fail++; $display("FAIL reset_imaddr got %h want 0", IMAddr); end
    n_checks++; if (IMData !== 32'h0) begin n_fail++; $display("FAIL reset_imdata got %h want 0", IMData); end
    n_checks++; if (Count !== 7'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", Count); end
    n_checks++; if ({Done, Full, Err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {Done, Full, Err}); end
  endtask

  task automatic test_program();
    logic [31:0] exp_data [6];
    exp_data[0] = 32'h0050_0093; exp_data[1] = 32'h4020_81B3; exp_data[2] = 32'h0020_A423;
    exp_data[3] = 32'hFE20_8EE3; exp_data[4] = 32'h0080_00EF; exp_data[5] = 32'h1234_52B7;
    do_reset();
    InValid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: set_fields(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5, 1'b0);
        1: set_fields(3'b111, 7'h33, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 32'd0, 1'b0);
        2: set_fields(3'b001, 7'h23, 5'd0, 5'd1, 5'd2, 3'b010, 7'h00, 32'd8, 1'b0);
        3: set_fields(3'b101, 7'h63, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'hFFFF_FFFC, 1'b0);
        4: set_fields(3'b110, 7'h6F, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd8, 1'b0);
        default: set_fields(3'b010, 7'h37, 5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'h1234_5000, 1'b1);
      endcase
      tick();
      n_checks++; if (IMWr !== 1'b1) begin n_fail++; $display("FAIL prog_imwr[%0d] got %b want 1", i, IMWr); end
      n_checks++; if (IMAddr !== 32'(4 * i)) begin n_fail++; $display("FAIL prog_imaddr[%0d] got %h want %h", i, IMAddr, 32'(4 * i)); end
      n_checks++; if (IMData !== exp_data[i]) begin n_fail++; $display("FAIL prog_imdata[%0d] got %h want %h", i, IMData, exp_data[i]); end
    end
    n_checks++; if (Count !== 7'd6) begin n_fail++; $display("FAIL prog_count got %0d want 6", Count); end
    n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL prog_done got %b want 1", Done); end
    n_checks++; if (InReady !== 1'b0) begin n_fail++; $display("FAIL prog_inready got %b want 0", InReady); end
    InLast = 1'b0;
    tick();
    n_checks++; if (IMWr !== 1'b0) begin n_fail++; $display("FAIL prog_after_imwr got %b want 0", IMWr); end
    n_checks++; if (IMData !== 32'h1234_52B7) begin n_fail++; $display("FAIL prog_hold_data got %h want 123452b7", IMData); end
    n_checks++; if (Count !== 7'd6 || Done !== 1'b1) begin n_fail++; $display("FAIL prog_after_state got count %0d done %b want 6 1", Count, Done); end
    InValid = 1'b0;
  endtask

  task automatic test_shift();
    do_reset();
    set_fields(3'b000, 7'h13, 5'd1, 5'd2, 5'd0, 3'b101, 7'h20, 32'd3, 1'b0);
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
    n_checks++; if (IMWr !== 1'b1 || IMData !== 32'h4031_5093) begin n_fail++; $display("FAIL srai got wr %b data %h want 1 40315093", IMWr, IMData); end
    // SLLI x4,x4,31 -> 0x01F21213
    set_fields(3'b000, 7'h13, 5'd4, 5'd4, 5'd0, 3'b001, 7'h00, 32'd31, 1'b0);
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
    n_checks++; if (IMData !== 32'h01F2_1213 || IMAddr !== 32'h4) begin n_fail++; $display("FAIL slli got data %h addr %h want 01f21213 4", IMData, IMAddr); end
  endtask

  task automatic test_illegal();
    do_reset();
    set_fields(3'b011, 7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5, 1'b0);
    InValid = 1'b1;
    tick();
    n_checks++; if (IMWr !== 1'b0) begin n_fail++; $display("FAIL illegal_imwr got %b want 0", IMWr); end
    n_checks++; if (Count !== 7'd0) begin n_fail++; $display("FAIL illegal_count got %0d want 0", Count); end
    n_checks++; if (Err !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %b want 1", Err); end
    set_addi(5'd2, 32'd7);
    tick();
    n_checks++; if (IMWr !== 1'b1 || IMAddr !== 32'h0 || IMData !== 32'h0070_0113) begin n_fail++; $display("FAIL illegal_next got wr %b addr %h data %h want 1 0 00700113", IMWr, IMAddr, IMData); end
    n_checks++; if (Err !== 1'b1 || Count !== 7'd1) begin n_fail++; $display("FAIL illegal_sticky got err %b count %0d want 1 1", Err, Count); end
    // Illegal format carrying InLast still ends the load.
    set_fields(3'b100, 7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd0, 1'b1);
    tick();
    InValid = 1'b0; InLast = 1'b0;
    n_checks++; if (IMWr !== 1'b0 || Done !== 1'b1 || Count !== 7'd1 || InReady !== 1'b0) begin n_fail++; $display("FAIL illegal_last got wr %b done %b count %0d rdy %b want 0 1 1 0", IMWr, Done, Count, InReady); end
    do_reset();
    tick();
    n_checks++; if (Err !== 1'b0) begin n_fail++; $display("FAIL illegal_clear got err %b want 0", Err); end
  endtask

  task automatic test_full();
    logic [31:0] exp;
    do_reset();
    s_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_addi(5'(k + 1), 32'(k + 1));
      tick();
      if (k < 4) begin
        exp = (32'(k + 1) << 20) | (32'(k + 1) << 7) | 32'h13;
        n_checks++; if (s_imwr !== 1'b1 || s_imaddr !== 32'(4 * k) || s_imdata !== exp) begin n_fail++; $display("FAIL full_write[%0d] got wr %b addr %h data %h want 1 %h %h", k, s_imwr, s_imaddr, s_imdata, 32'(4 * k), exp); end
        n_checks++; if (s_count !== 3'(k + 1)) begin n_fail++; $display("FAIL full_count[%0d] got %0d want %0d", k, s_count, k + 1); end
      end else begin
        n_checks++; if (s_imwr !== 1'b0 || s_count !== 3'd4) begin n_fail++; $display("FAIL full_blocked[%0d] got wr %b count %0d want 0 4", k, s_imwr, s_count); end
      end
      if (k == 3) begin
        n_checks++; if (s_full !== 1'b1 || s_done !== 1'b1 || s_ready !== 1'b0) begin n_fail++; $display("FAIL full_flags got full %b done %b rdy %b want 1 1 0", s_full, s_done, s_ready); end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_toggle();
    int nw;
    nw = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      InValid = (i % 2 == 0);
      set_addi(5'(i), 32'(i));
      tick();
      if (i % 2 == 0) begin
        n_checks++; if (IMWr !== 1'b1 || IMAddr !== 32'(4 * nw)) begin n_fail++; $display("FAIL toggle_write[%0d] got wr %b addr %h want 1 %h", i, IMWr, IMAddr, 32'(4 * nw)); end
        nw++;
      end else begin
        n_checks++; if (IMWr !== 1'b0) begin n_fail++; $display("FAIL toggle_idle[%0d] got wr %b want 0", i, IMWr); end
      end
    end
    InValid = 1'b0;
    n_checks++; if (Count !== 7'd4) begin n_fail++; $display("FAIL toggle_count got %0d want 4", Count); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    set_addi(5'd1, 32'd1);
    InValid = 1'b1;
    tick();
    InValid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (IMWr !== 1'b0 || Count !== 7'd0 || IMAddr !== 32'h0 || IMData !== 32'h0) begin n_fail++; $display("FAIL rstmid_state got wr %b count %0d addr %h data %h want 0 0 0 0", IMWr, Count, IMAddr, IMData); end
    // Reset wins over a simultaneous valid bundle.
    rst = 1'b1; InValid = 1'b1;
    tick();
    rst = 1'b0; InValid = 1'b0;
    n_checks++; if (IMWr !== 1'b0 || Count !== 7'd0) begin n_fail++; $display("FAIL rst_priority got wr %b count %0d want 0 0", IMWr, Count); end
    set_addi(5'd7, 32'd9);
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
    n_checks++; if (IMWr !== 1'b1 || IMAddr !== 32'h0 || IMData !== 32'h0090_0393) begin n_fail++; $display("FAIL rstmid_next got wr %b addr %h data %h want 1 0 00900393", IMWr, IMAddr, IMData); end
  endtask

  initial begin
    rst = 1'b1; s_rst = 1'b1; InValid = 1'b0; s_valid = 1'b0;
    set_fields(3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'd0, 1'b0);
    test_reset();
    test_program();
    test_shift();
    test_illegal();
    test_full();
    test_toggle();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
